mouse_cannon_ctrl: RTL and testbench
====================================

# mouse_cannon_ctrl

Converts decoded PS/2 mouse packets into player-cannon controls for the Space Invaders core. Sits directly downstream of the mouse packet decoder, consuming its per-packet X movement and button state. Produces a clamped horizontal cannon position for the renderer, and a fire-request handshake for the shot engine with cooldown. Also emits a pause-toggle pulse for the game FSM.

## Interface
- `X_MAX`, 640: screen width in pixels.
- `CANNON_W`, 32: cannon sprite width in pixels; the right limit is `X_MAX-CANNON_W`.
- `X_INIT`, 304: reset and recenter position.
- `SPEED_SHIFT`, 1: mouse delta is arithmetic-shifted right by this amount before being applied.
- `COOLDOWN`, 12_500_000: cycles between the end of a fire handshake and the next accepted shot (0.25 s at 50 MHz).

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `m_done_tick` in 1: one-cycle strobe; `xm` and `btnm` are valid in this cycle.
- `xm` in 9: signed two's-complement X movement.
- `btnm` in 3: button bits, with [0] left, [1] right, [2] middle.
- `game_en` in 1: high while gameplay is active.
- `fire_ack` in 1: shot engine accepted the request.
- `cannon_x` out 10: left edge of the cannon, in pixels.
- `fire_req` out 1: level request, held until acknowledged.
- `pause_toggle` out 1: one-cycle pulse.

## Operation
- **Reset values:** `cannon_x=X_INIT`, `fire_req=0`, `pause_toggle=0`, FSM=IDLE, cooldown counter=0, previous-button register=000.
- **Previous-button register:** loaded with `btnm` on every `m_done_tick`, regardless of `game_en`.
- **Edge definition:** a button edge is `btnm[i]=1` while its previous bit is 0, evaluated on `m_done_tick` only.
- **Position update:** applied on `m_done_tick` with `game_en=1`.
  - delta = sign-extend(`xm`) >>> `SPEED_SHIFT`.
  - sum = `cannon_x` + delta, computed in 12-bit signed.
  - Result is clamped to [0, `X_MAX-CANNON_W`]; no wrap-around.
- **Recenter:** right button held (level, not edge) on a tick with `game_en=1` sets `cannon_x=X_INIT`. Recenter overrides movement in that packet.
- **Frozen position:** `game_en=0` freezes `cannon_x`.
- **Pause:** a middle-button edge pulses `pause_toggle` for one cycle. This works independently of `game_en`.
- **Fire FSM:**
  - IDLE: a left edge with `game_en=1` moves to REQ.
  - REQ: `fire_req=1`. `fire_ack=1` moves to COOL and loads the counter with `COOLDOWN-1`. `game_en=0` aborts to IDLE with no cooldown.
  - COOL: the counter decrements each cycle and moves to IDLE when it reaches 0. `game_en` is ignored in COOL.
- **Dropped presses:** left edges in REQ or COOL are discarded, not queued.
- **`fire_ack` sampling:** sampled only in REQ; ack in any other state is ignored.
- **Simultaneous buttons:** left and right pressed in the same packet both take effect (recenter and fire). Middle is handled independently of the other two.

## Timing
- `cannon_x` and `pause_toggle` change in the cycle after `m_done_tick`.
- `fire_req` rises in the cycle after the `m_done_tick` carrying the left edge.
- `fire_req` falls in the cycle after `fire_ack` is sampled high in REQ.
- An ack in the first cycle of REQ is legal, giving a minimum request width of 1 cycle.
- Minimum spacing between consecutive `fire_req` rises is 1 + ack latency + `COOLDOWN` + 1 cycles.
- Reset asserted mid-handshake or mid-cooldown returns every output to its reset value immediately and asynchronously.
- All outputs are registered.

## Structure
- **Shared package `si_pkg`:** `X_MAX`, `CANNON_W`, `X_INIT`, and the fire FSM state encoding (IDLE=0, REQ=1, COOL=2).
- **Sub-module `mouse_btn_edge`:** the previous-button register plus the 3-bit edge detector gated by `m_done_tick`. Its outputs are `edge[2:0]` and `held[2:0]`.
- **Top module:** the position datapath, the fire FSM and cooldown counter, and the pause pulse.

## Test plan
- **Positive move:** reset, then tick with `xm=+40`, `SPEED_SHIFT=1` → `cannon_x=324` on the next cycle.
- **Clamping:** from 600, tick `xm=+255` → `cannon_x=608`. From 5, tick `xm=-256` (0x100) → `cannon_x=0`.
- **Fire handshake:** tick `btnm=001` → `fire_req=1` the next cycle. `fire_ack` 3 cycles later → `fire_req=0`. A left press 5 cycles later (after release) produces no request. A press after `COOLDOWN` (set to 20 in the bench) produces a new request.
- **Button hold:** holding left over 4 consecutive packets → exactly one `fire_req`. Tick `btnm=011` at `cannon_x=100` → `cannon_x=304` and `fire_req=1`.
- **Disabled game:** `game_en=0`, tick `xm=+50`, `btnm=101` → `cannon_x` unchanged, no `fire_req`, `pause_toggle` pulses for 1 cycle. `game_en` dropping while in REQ → `fire_req=0` the next cycle, FSM in IDLE.
- **Mid-cooldown reset:** assert `reset_n=0` during COOL → all outputs at reset values with no clock edge. After release, a left edge gives `fire_req` with no residual cooldown.

Source files
------------

// File: rtl/si_pkg.sv
// Shared Space Invaders constants: screen geometry and fire FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package si_pkg;

   localparam int X_MAX    = 640;
   localparam int CANNON_W = 32;
   localparam int X_INIT   = 304;

   typedef enum logic [1:0] {
      FIRE_IDLE = 2'd0,
      FIRE_REQ  = 2'd1,
      FIRE_COOL = 2'd2
   } fire_state_e;

endpackage

// File: rtl/mouse_btn_edge.sv
// Mouse button rise detector: remembers last packet's buttons, flags new presses.
// Latency: edge/held are combinational in the m_done_tick cycle; history updates on the next edge.
// Backpressure: none, every packet strobe is consumed.
module mouse_btn_edge (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m_done_tick,
   input  logic [2:0] btnm,
   output logic [2:0] btn_edge,
   output logic [2:0] btn_held
);

   logic [2:0] prev_q;

   // Capture every packet's button state, whether or not gameplay is running.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q <= 3'b000;
      end else if (m_done_tick) begin
         prev_q <= btnm;
      end
   end

   // Edges and levels only mean something in the packet-valid cycle.
   assign btn_edge = m_done_tick ? (btnm & ~prev_q) : 3'b000;
   assign btn_held = m_done_tick ? btnm : 3'b000;

endmodule

// File: rtl/mouse_cannon_ctrl.sv
// Mouse packets to cannon position, fire request handshake with cooldown, and pause pulse.
// Latency: all outputs registered, one cycle after m_done_tick / fire_ack.
// Backpressure: fire_req held until fire_ack; presses during REQ/COOL are dropped, not queued.
module mouse_cannon_ctrl
   import si_pkg::*;
#(
   parameter int          SPEED_SHIFT = 1,
   parameter int unsigned COOLDOWN    = 12_500_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       m_done_tick,
   input  logic [8:0] xm,
   input  logic [2:0] btnm,
   input  logic       game_en,
   input  logic       fire_ack,
   output logic [9:0] cannon_x,
   output logic       fire_req,
   output logic       pause_toggle
);

   localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam logic signed [11:0] X_RIGHT = 12'(X_MAX - CANNON_W);
   localparam logic [9:0]         X_HOME  = 10'(X_INIT);

   logic [2:0]              btn_edge;
   logic [2:0]              btn_held;
   logic                    unused_btn;

   logic [9:0]              cannon_x_q, cannon_x_d;
   logic signed [11:0]      delta;
   logic signed [11:0]      sum;

   fire_state_e             state_q;
   logic                    fire_req_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    pause_q;

   mouse_btn_edge u_btn (
      .clk         (clk),
      .reset_n     (reset_n),
      .m_done_tick (m_done_tick),
      .btnm        (btnm),
      .btn_edge    (btn_edge),
      .btn_held    (btn_held)
   );

   // Right-button edge and left/middle levels have no consumer here.
   assign unused_btn = ^{btn_edge[1], btn_held[2], btn_held[0]};

   // 12-bit signed arithmetic leaves headroom so the clamp never sees a wrapped value.
   assign delta = $signed({{3{xm[8]}}, xm}) >>> SPEED_SHIFT;
   assign sum   = $signed({2'b00, cannon_x_q}) + delta;

   // Next position: recenter beats movement; movement is clamped to the visible range.
   always_comb begin
      cannon_x_d = cannon_x_q;
      if (m_done_tick && game_en) begin
         if (btn_held[1]) begin
            cannon_x_d = X_HOME;
         end else if (sum < 12'sd0) begin
            cannon_x_d = 10'd0;
         end else if (sum > X_RIGHT) begin
            cannon_x_d = X_RIGHT[9:0];
         end else begin
            cannon_x_d = sum[9:0];
         end
      end
   end

   // Position register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cannon_x_q <= X_HOME;
      end else begin
         cannon_x_q <= cannon_x_d;
      end
   end

   // Pause pulse follows a middle-button press regardless of gameplay state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= btn_edge[2];
      end
   end

   // Fire FSM with registered request; ack wins over a simultaneous game_en drop
   // because the shot has already been taken by the engine.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= FIRE_IDLE;
         fire_req_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            FIRE_IDLE: begin
               if (btn_edge[0] && game_en) begin
                  state_q    <= FIRE_REQ;
                  fire_req_q <= 1'b1;
               end
            end
            FIRE_REQ: begin
               if (fire_ack) begin
                  state_q    <= FIRE_COOL;
                  fire_req_q <= 1'b0;
                  cnt_q      <= CNT_W'(COOLDOWN - 1);
               end else if (!game_en) begin
                  state_q    <= FIRE_IDLE;
                  fire_req_q <= 1'b0;
               end
            end
            FIRE_COOL: begin
               if (cnt_q == '0) begin
                  state_q <= FIRE_IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q    <= FIRE_IDLE;
               fire_req_q <= 1'b0;
               cnt_q      <= '0;
            end
         endcase
      end
   end

   assign cannon_x     = cannon_x_q;
   assign fire_req     = fire_req_q;
   assign pause_toggle = pause_q;

endmodule

// File: tb/tb_mouse_cannon_ctrl.sv
// Directed bench for mouse_cannon_ctrl with a short cooldown.
// Latency: n/a.
// Backpressure: n/a.
module tb_mouse_cannon_ctrl;

   logic       clk;
   logic       reset_n;
   logic       m_done_tick;
   logic [8:0] xm;
   logic [2:0] btnm;
   logic       game_en;
   logic       fire_ack;
   logic [9:0] cannon_x;
   logic       fire_req;
   logic       pause_toggle;

   int checks;
   int errors;
   int rises;
   int rise_base;
   logic req_prev;

   mouse_cannon_ctrl #(
      .SPEED_SHIFT (1),
      .COOLDOWN    (20)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .m_done_tick  (m_done_tick),
      .xm           (xm),
      .btnm         (btnm),
      .game_en      (game_en),
      .fire_ack     (fire_ack),
      .cannon_x     (cannon_x),
      .fire_req     (fire_req),
      .pause_toggle (pause_toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count fire_req rising edges, sampled away from the active edge.
   initial begin
      rises    = 0;
      req_prev = 1'b0;
   end
   always @(negedge clk) begin
      if (fire_req === 1'b1 && req_prev !== 1'b1) rises <= rises + 1;
      req_prev <= fire_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one packet for a single cycle; returns at the following negedge.
   task automatic tick(input logic [8:0] x, input logic [2:0] b);
      xm          = x;
      btnm        = b;
      m_done_tick = 1'b1;
      @(negedge clk);
      m_done_tick = 1'b0;
      xm          = 9'd0;
   endtask

   task automatic ack_pulse();
      fire_ack = 1'b1;
      @(negedge clk);
      fire_ack = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset_n     = 1'b0;
      m_done_tick = 1'b0;
      xm          = 9'd0;
      btnm        = 3'b000;
      game_en     = 1'b1;
      fire_ack    = 1'b0;
      cyc(2);
      check("rst_x",     32'(cannon_x), 32'd304);
      check("rst_req",   32'(fire_req), 32'd0);
      check("rst_pause", 32'(pause_toggle), 32'd0);
      reset_n = 1'b1;
      cyc(1);

      // Movement and clamping
      tick(9'd40, 3'b000);   check("move_pos", 32'(cannon_x), 32'd324);
      tick(9'd255, 3'b000);  check("move_451", 32'(cannon_x), 32'd451);
      tick(9'd255, 3'b000);
      tick(9'd44, 3'b000);   check("move_600", 32'(cannon_x), 32'd600);
      tick(9'd255, 3'b000);  check("clamp_hi", 32'(cannon_x), 32'd608);
      repeat (4) tick(9'h100, 3'b000);
      check("move_96", 32'(cannon_x), 32'd96);
      tick(9'h14A, 3'b000);  check("move_5", 32'(cannon_x), 32'd5);
      tick(9'h100, 3'b000);  check("clamp_lo", 32'(cannon_x), 32'd0);

      // Fire handshake, dropped press in cooldown, press after cooldown
      tick(9'd0, 3'b001);    check("fire_rise", 32'(fire_req), 32'd1);
      cyc(2);                check("fire_hold", 32'(fire_req), 32'd1);
      ack_pulse();           check("fire_fall", 32'(fire_req), 32'd0);
      tick(9'd0, 3'b000);
      tick(9'd0, 3'b001);    check("cool_drop0", 32'(fire_req), 32'd0);
      cyc(2);                check("cool_drop1", 32'(fire_req), 32'd0);
      cyc(25);
      tick(9'd0, 3'b000);
      tick(9'd0, 3'b001);    check("fire_again", 32'(fire_req), 32'd1);
      ack_pulse();           check("fire_again_fall", 32'(fire_req), 32'd0);
      cyc(25);

      // Holding left across four packets fires once
      tick(9'd0, 3'b000);
      rise_base = rises;
      tick(9'd0, 3'b001);    check("hold_rise", 32'(fire_req), 32'd1);
      ack_pulse();
      cyc(25);
      repeat (3) begin
         tick(9'd0, 3'b001);
         cyc(1);
      end
      cyc(2);
      check("hold_once", 32'(rises - rise_base), 32'd1);
      check("hold_req",  32'(fire_req), 32'd0);

      // Recenter plus fire in the same packet
      tick(9'd200, 3'b000);  check("move_100", 32'(cannon_x), 32'd100);
      tick(9'd20, 3'b011);
      check("recenter_x",   32'(cannon_x), 32'd304);
      check("recenter_req", 32'(fire_req), 32'd1);
      ack_pulse();
      cyc(25);

      // Gameplay disabled: frozen, no fire, pause still works
      tick(9'd0, 3'b000);
      game_en = 1'b0;
      tick(9'd50, 3'b101);
      check("dis_x",     32'(cannon_x), 32'd304);
      check("dis_req",   32'(fire_req), 32'd0);
      check("dis_pause", 32'(pause_toggle), 32'd1);
      cyc(1);                check("pause_1cyc", 32'(pause_toggle), 32'd0);

      // game_en drop while requesting aborts without cooldown
      game_en = 1'b1;
      tick(9'd0, 3'b000);
      tick(9'd0, 3'b001);    check("abort_rise", 32'(fire_req), 32'd1);
      game_en = 1'b0;
      cyc(1);                check("abort_fall", 32'(fire_req), 32'd0);
      game_en = 1'b1;
      tick(9'd0, 3'b000);
      tick(9'd0, 3'b001);    check("abort_idle", 32'(fire_req), 32'd1);

      // Asynchronous reset during cooldown
      tick(9'd40, 3'b001);
      check("pre_x",   32'(cannon_x), 32'd324);
      check("pre_req", 32'(fire_req), 32'd1);
      ack_pulse();
      cyc(2);
      tick(9'd0, 3'b101);    check("pre_pause", 32'(pause_toggle), 32'd1);
      reset_n = 1'b0;
      #1;
      check("arst_x",     32'(cannon_x), 32'd304);
      check("arst_req",   32'(fire_req), 32'd0);
      check("arst_pause", 32'(pause_toggle), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(9'd0, 3'b001);    check("post_rst_fire", 32'(fire_req), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
